// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter and its round-robin core.
// The read-tag record is sized for the largest supported requester count.
package ram_port_arbiter_pkg;

   localparam int MAX_N_REQ = 8;
   localparam int MAX_IDX_W = $clog2(MAX_N_REQ);

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [MAX_IDX_W-1:0] idx;
   } rd_tag_t;

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin arbiter: combinational one-hot grant, searching cyclically from
// a registered pointer that moves just past the last winner.
module rr_arbiter_core
   import ram_port_arbiter_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_async_rst_n,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_gnt_idx
);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
         if (!found && i_req[cand]) begin
            found       = 1'b1;
            o_gnt[cand] = 1'b1;
            o_gnt_idx   = cand;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_async_rst_n) begin
      if (!i_async_rst_n) begin
         ptr_q <= '0;
      end else if (found) begin
         ptr_q <= (o_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : o_gnt_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between N_REQ requesters: round-robin grant,
// registered RAM command, and a tag pipeline steering read returns.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int WORD_BIT_WIDTH      = 32,
   parameter int WORD_ADDR_BIT_WIDTH = 3,
   parameter int N_REQ               = 2,
   parameter int RAM_RD_LATENCY      = 2
) (
   input  logic                                  i_clk,
   input  logic                                  i_async_rst_n,
   input  logic [N_REQ-1:0]                      i_req,
   input  logic [N_REQ-1:0]                      i_we,
   input  logic [N_REQ*WORD_ADDR_BIT_WIDTH-1:0]  i_word_addr,
   input  logic [N_REQ*WORD_BIT_WIDTH-1:0]       i_wr_data,
   input  logic [N_REQ*WORD_BIT_WIDTH/8-1:0]     i_wr_byte_en,
   output logic [N_REQ-1:0]                      o_gnt,
   output logic [N_REQ-1:0]                      o_rd_valid,
   output logic [WORD_BIT_WIDTH-1:0]             o_rd_data,
   output logic                                  o_ram_we,
   output logic [WORD_ADDR_BIT_WIDTH-1:0]        o_ram_word_addr,
   output logic [WORD_BIT_WIDTH-1:0]             o_ram_wr_data,
   output logic [WORD_BIT_WIDTH/8-1:0]           o_ram_wr_byte_en,
   input  logic [WORD_BIT_WIDTH-1:0]             i_ram_rd_data
);

   localparam int W     = WORD_BIT_WIDTH;
   localparam int AW    = WORD_ADDR_BIT_WIDTH;
   localparam int BE_W  = WORD_BIT_WIDTH / 8;
   localparam int IDX_W = idx_width(N_REQ);

   if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0) begin : g_bad_word_width
      $error("WORD_BIT_WIDTH must be a power of 2 and at least 8");
   end
   if (N_REQ < 2 || N_REQ > MAX_N_REQ) begin : g_bad_n_req
      $error("N_REQ must be in 2..8");
   end
   if (RAM_RD_LATENCY < 1) begin : g_bad_latency
      $error("RAM_RD_LATENCY must be at least 1");
   end

   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             any_gnt;

   rr_arbiter_core #(.N_REQ(N_REQ)) u_arb (
      .i_clk         (i_clk),
      .i_async_rst_n (i_async_rst_n),
      .i_req         (i_req),
      .o_gnt         (gnt),
      .o_gnt_idx     (gnt_idx)
   );

   assign o_gnt   = gnt;
   assign any_gnt = |gnt;

   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [W-1:0]    sel_data;
   logic [BE_W-1:0] sel_be;

   always_comb begin
      sel_we   = i_we[gnt_idx];
      sel_addr = i_word_addr[int'(gnt_idx)*AW +: AW];
      sel_data = i_wr_data[int'(gnt_idx)*W +: W];
      sel_be   = i_wr_byte_en[int'(gnt_idx)*BE_W +: BE_W];
   end

   // Address and data hold when idle; only we/byte_en are forced inactive.
   always_ff @(posedge i_clk or negedge i_async_rst_n) begin
      if (!i_async_rst_n) begin
         o_ram_we         <= 1'b0;
         o_ram_word_addr  <= '0;
         o_ram_wr_data    <= '0;
         o_ram_wr_byte_en <= '0;
      end else if (any_gnt) begin
         o_ram_we         <= sel_we;
         o_ram_word_addr  <= sel_addr;
         o_ram_wr_data    <= sel_data;
         o_ram_wr_byte_en <= sel_be;
      end else begin
         o_ram_we         <= 1'b0;
         o_ram_wr_byte_en <= '0;
      end
   end

   // Tags travel RAM_RD_LATENCY stages, then the output register is the last
   // stage, so a read granted at T returns at T+1+RAM_RD_LATENCY.
   rd_tag_t          tag_q [RAM_RD_LATENCY];
   rd_tag_t          tag_d;
   rd_tag_t          tag_last;
   logic [N_REQ-1:0] rd_valid_d;
   logic             tag_idx_unused;

   always_comb begin
      tag_d       = '0;
      tag_d.valid = any_gnt & ~sel_we;
      tag_d.idx   = MAX_IDX_W'(gnt_idx);
   end

   assign tag_last       = tag_q[RAM_RD_LATENCY-1];
   assign tag_idx_unused = ^tag_last.idx;

   always_comb begin
      rd_valid_d = '0;
      if (tag_last.valid) begin
         rd_valid_d[tag_last.idx[IDX_W-1:0]] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_async_rst_n) begin
      if (!i_async_rst_n) begin
         for (int i = 0; i < RAM_RD_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
         o_rd_valid <= '0;
         o_rd_data  <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int i = 1; i < RAM_RD_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         o_rd_valid <= rd_valid_d;
         if (tag_last.valid) begin
            o_rd_data <= i_ram_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter with a behavioural RAM,
// an array-based reference memory and a read-return scoreboard.
module tb_ram_port_arbiter;

   localparam int W     = 32;
   localparam int AW    = 3;
   localparam int N     = 2;
   localparam int L     = 2;
   localparam int BE    = W / 8;
   localparam int DEPTH = 1 << AW;
   localparam int AVW   = N * AW;
   localparam int DVW   = N * W;
   localparam int BVW   = N * BE;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [N-1:0]    req        = '0;
   logic [N-1:0]    we         = '0;
   logic [AVW-1:0]  word_addr  = '0;
   logic [DVW-1:0]  wr_data    = '0;
   logic [BVW-1:0]  wr_byte_en = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rd_valid;
   logic [W-1:0]    rd_data;
   logic            ram_we;
   logic [AW-1:0]   ram_addr;
   logic [W-1:0]    ram_wdata;
   logic [BE-1:0]   ram_be;
   logic [W-1:0]    ram_q = '0;

   ram_port_arbiter #(
      .WORD_BIT_WIDTH(W), .WORD_ADDR_BIT_WIDTH(AW), .N_REQ(N), .RAM_RD_LATENCY(L)
   ) dut (
      .i_clk            (clk),
      .i_async_rst_n    (rst_n),
      .i_req            (req),
      .i_we             (we),
      .i_word_addr      (word_addr),
      .i_wr_data        (wr_data),
      .i_wr_byte_en     (wr_byte_en),
      .o_gnt            (gnt),
      .o_rd_valid       (rd_valid),
      .o_rd_data        (rd_data),
      .o_ram_we         (ram_we),
      .o_ram_word_addr  (ram_addr),
      .o_ram_wr_data    (ram_wdata),
      .o_ram_wr_byte_en (ram_be),
      .i_ram_rd_data    (ram_q)
   );

   function automatic logic [W-1:0] merge(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                          input logic [BE-1:0] b);
      logic [W-1:0] r;
      r = old_w;
      for (int i = 0; i < BE; i++) begin
         if (b[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return r;
   endfunction

   // Write-first RAM environment; read data is ready one cycle after the
   // command is presented, so the arbiter can register it L cycles after grant.
   logic [W-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (ram_we) begin
         ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_be);
         ram_q             <= merge(ram_mem[ram_addr], ram_wdata, ram_be);
      end else begin
         ram_q <= ram_mem[ram_addr];
      end
   end

   // ---------------- reference model and scoreboard ----------------
   int            n_checks = 0;
   int            n_pass   = 0;
   int            ref_ptr  = 0;
   logic [W-1:0]  ref_mem [DEPTH];
   logic          exp_we   = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [W-1:0]  exp_data = '0;
   logic [BE-1:0] exp_be   = '0;
   logic [W-1:0]  exp_q[$];
   int            exp_idx_q[$];
   int            exp_due_q[$];

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor: every read return is popped against the oldest outstanding read.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_valid != '0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rd_unexpected: got o_rd_valid=%b, expected no return (cycle %0d)", rd_valid, cyc);
            end else begin
               chk("rd_valid", W'(rd_valid), W'(1) << exp_idx_q[0]);
               chk("rd_data", rd_data, exp_q[0]);
               chk("rd_cycle", W'(cyc), W'(exp_due_q[0]));
               void'(exp_q.pop_front());
               void'(exp_idx_q.pop_front());
               void'(exp_due_q.pop_front());
            end
         end else if (exp_q.size() != 0 && exp_due_q[0] <= cyc) begin
            n_checks++;
            $display("FAIL rd_missing: got no return, expected requester %0d data 0x%0h at cycle %0d",
                     exp_idx_q[0], exp_q[0], exp_due_q[0]);
            void'(exp_q.pop_front());
            void'(exp_idx_q.pop_front());
            void'(exp_due_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; checks last cycle's command, drives one cycle.
   task automatic step(input logic [N-1:0] p_req, input logic [N-1:0] p_we,
                       input logic [AVW-1:0] p_addr, input logic [DVW-1:0] p_data,
                       input logic [BVW-1:0] p_be);
      int           g;
      logic [N-1:0] exp_gnt;
      chk("ram_we", W'(ram_we), W'(exp_we));
      chk("ram_addr", W'(ram_addr), W'(exp_addr));
      chk("ram_wr_data", ram_wdata, exp_data);
      chk("ram_byte_en", W'(ram_be), W'(exp_be));
      req = p_req; we = p_we; word_addr = p_addr; wr_data = p_data; wr_byte_en = p_be;
      #1;
      g = -1;
      for (int i = 0; i < N; i++) begin
         int k = (ref_ptr + i) % N;
         if (g < 0 && p_req[k]) g = k;
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      chk("gnt", W'(gnt), W'(exp_gnt));
      if (g >= 0) begin
         ref_ptr  = (g + 1) % N;
         exp_we   = p_we[g];
         exp_addr = p_addr[g*AW +: AW];
         exp_data = p_data[g*W +: W];
         exp_be   = p_be[g*BE +: BE];
         if (p_we[g]) begin
            ref_mem[exp_addr] = merge(ref_mem[exp_addr], exp_data, exp_be);
         end else begin
            exp_q.push_back(ref_mem[exp_addr]);
            exp_idx_q.push_back(g);
            exp_due_q.push_back(cyc + 1 + L);
         end
      end else begin
         exp_we = 1'b0;
         exp_be = '0;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0);
   endtask

   task automatic one(input int k, input logic w, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic [BE-1:0] b);
      logic [N-1:0]   rq;
      logic [N-1:0]   wv;
      logic [AVW-1:0] av;
      logic [DVW-1:0] dv;
      logic [BVW-1:0] bv;
      rq = '0; wv = '0; av = '0; dv = '0; bv = '0;
      rq[k] = 1'b1; wv[k] = w;
      av[k*AW +: AW] = a; dv[k*W +: W] = d; bv[k*BE +: BE] = b;
      step(rq, wv, av, dv, bv);
   endtask

   // In-flight reads are forgotten and the pointer restarts at 0.
   task automatic do_reset(input int n);
      rst_n = 1'b0;
      req = '0;
      exp_q.delete(); exp_idx_q.delete(); exp_due_q.delete();
      ref_ptr = 0;
      exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_be = '0;
      repeat (n) @(negedge clk);
      chk("rst_ram_we", W'(ram_we), '0);
      chk("rst_ram_addr", W'(ram_addr), '0);
      chk("rst_ram_wr_data", ram_wdata, '0);
      chk("rst_ram_byte_en", W'(ram_be), '0);
      chk("rst_rd_valid", W'(rd_valid), '0);
      chk("rst_rd_data", rd_data, '0);
      chk("rst_gnt", W'(gnt), '0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      @(negedge clk);
      do_reset(3);
      idle(10);

      one(0, 1'b1, 3'd3, 32'hDEADBEEF, 4'hF);
      idle(2);
      one(0, 1'b0, 3'd3, '0, 4'hF);
      idle(5);

      one(0, 1'b1, 3'd1, 32'h11, 4'hF);
      one(1, 1'b1, 3'd2, 32'h22, 4'hF);
      for (int i = 0; i < 8; i++) step(2'b11, 2'b00, {3'd2, 3'd1}, '0, 8'hFF);
      idle(5);

      one(1, 1'b1, 3'd5, 32'hFFFFFFFF, 4'hF);
      one(1, 1'b1, 3'd5, 32'h000000AA, 4'h1);
      one(0, 1'b0, 3'd5, '0, 4'hF);
      idle(5);

      one(0, 1'b0, 3'd3, '0, 4'hF);
      one(0, 1'b0, 3'd5, '0, 4'hF);
      do_reset(1);
      idle(6);
      step(2'b11, 2'b00, {3'd4, 3'd6}, '0, 8'hFF);
      idle(5);

      for (int a = 0; a < DEPTH; a++) one(1, 1'b0, AW'(a), '0, 4'hF);
      idle(5);

      for (int i = 0; i < 300; i++) begin
         step(N'($urandom_range(0, 3)), N'($urandom_range(0, 3)), AVW'($urandom),
              {$urandom, $urandom}, BVW'($urandom));
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      idle(2);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d reads outstanding, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
